sevenseg_scan: RTL and testbench
================================

Name: sevenseg_scan

Overview:
- Time-multiplexed scan driver for an N-digit 7-segment display.
- Sits directly upstream of the combinational hex-to-segment decoder: drives that decoder's 4-bit nibble input and the per-digit common enables.
- Cycles through digits at a programmable refresh rate.
- Double-buffers the displayed value so a new value is only shown from the start of a frame, which prevents tearing.

Parameters:
- NUM_DIGITS, 4, number of display digits (≥1)
- REFRESH_DIV, 1000, clk cycles per digit dwell (≥1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- enable_i  input  1  scan enable; low freezes scanning and blanks all digits
- load_i  input  1  one-cycle strobe to capture value_i
- value_i  input  4*NUM_DIGITS  packed nibbles; digit 0 = bits [3:0]
- blank_i  input  NUM_DIGITS  per-digit forced blank mask (1 = off)
- x_o  output  4  nibble to the segment decoder
- digit_en_o  output  NUM_DIGITS  one-hot active-high digit enable
- frame_done_o  output  1  one-cycle pulse when the last digit's dwell ends

Behaviour:
- Reset (async, active-high): prescaler=0, idx=0, shadow=0, display=0, x_o=0, digit_en_o=0, frame_done_o=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while enable_i=1.
  - tick = (count==REFRESH_DIV-1); count wraps to 0 on tick.
  - REFRESH_DIV=1 gives tick every enabled cycle.
  - Counter width $clog2(REFRESH_DIV), minimum 1 bit.
- Digit index:
  - On tick, idx advances by 1 and wraps from NUM_DIGITS-1 to 0.
  - Wrap cycle asserts frame_done_o (registered, high exactly one cycle, the cycle after the wrap tick).
- Load:
  - load_i=1 copies value_i into shadow.
  - display ← shadow on every wrap tick (frame boundary).
  - load_i coincident with the wrap tick: display ← value_i directly (the new value wins); shadow also updated.
  - Multiple loads within one frame: the last one wins.
- Outputs (registered, one-cycle latency from idx/display):
  - x_o = display[4*idx +: 4].
  - digit_en_o = (1<<idx) & ~blank_i when enable_i=1, else all zero.
  - blank_i affects only digit_en_o, never x_o.
- enable_i=0:
  - Prescaler and idx hold; digit_en_o=0; frame_done_o=0.
  - load_i still captures into shadow.
  - On re-enable, scanning resumes from the held count and idx.
- Mid-operation reset returns every output to its reset value immediately, without waiting for clk.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SEVENSEG_SCAN_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - A digit is blanked (digit_en_o bit forced 0) if its nibble and all higher-index nibbles of display are 0.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - Combined with blank_i by OR.
- Undefined: all digits are shown unless blank_i masks them.

Decomposition:
- Package sevenseg_pkg:
  - NIBBLE_W=4 constant.
  - Default NUM_DIGITS and REFRESH_DIV constants.
  - Typedef nibble_t (logic [3:0]).
- Sub-module sevenseg_tick_gen (prescaler):
  - Parameter DIV; ports clk, rst, en → tick.
  - Reusable by other display/timer blocks.
- Idx/shadow/display/output registers stay in the top.

Test Plan:
- Reset then run (NUM_DIGITS=4, REFRESH_DIV=4, enable_i=1, value 0x1234 loaded once) → x_o sequence 4,3,2,1 reversed per idx (0:4, 1:3, 2:2, 3:1); digit_en_o 0001,0010,0100,1000; each held 4 cycles; frame_done_o pulses once per 16 cycles.
- Load 0xABCD mid-frame while showing 0x1234 → remaining digits of the current frame still show 1234 nibbles; the next frame shows D,C,B,A.
- load_i asserted exactly on the wrap-tick cycle with 0x5555 → the very next frame shows 5 on all digits.
- blank_i=4'b0101 → digit_en_o bits 0 and 2 never assert; x_o still cycles through all nibbles.
- enable_i dropped for 10 cycles at idx=2, count=1 → digit_en_o=0 and no frame_done_o; after re-enable, idx=2 remains for 3 more cycles.
- Async rst pulsed mid-dwell → all outputs are 0 before the next clk edge; after release, the scan restarts at idx 0. With SEVENSEG_SCAN_LZ_BLANK_EN and value 0x0040 → only digits 0 and 1 enabled.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the seven-segment display blocks.
package sevenseg_pkg;
  localparam int NIBBLE_W        = 4;
  localparam int DEF_NUM_DIGITS  = 4;
  localparam int DEF_REFRESH_DIV = 1000;

  typedef logic [NIBBLE_W-1:0] nibble_t;
endpackage

// File: rtl/sevenseg_tick_gen.sv
// Enable-gated prescaler: pulses tick on the last count of every DIV enabled cycles.
module sevenseg_tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = en && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (en) count_d = tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/sevenseg_scan.sv
// Double-buffered, time-multiplexed scan driver for an N-digit 7-segment display.
// Define SEVENSEG_SCAN_LZ_BLANK_EN to enable leading-zero suppression.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable_i,
  input  logic                           load_i,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]          blank_i,
  output nibble_t                        x_o,
  output logic [NUM_DIGITS-1:0]          digit_en_o,
  output logic                           frame_done_o
);
  localparam int            IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int            VW       = NIBBLE_W * NUM_DIGITS;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic                  tick, wrap;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         shadow_q, shadow_d, display_q, display_d;
  nibble_t               x_q, x_d;
  logic [NUM_DIGITS-1:0] en_q, en_d, lz_off;
  logic                  fd_q, fd_d;

  sevenseg_tick_gen #(.DIV(REFRESH_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (enable_i),
    .tick (tick)
  );

`ifdef SEVENSEG_SCAN_LZ_BLANK_EN
  logic zero_run;

  // Walk down from the top digit; digit 0 is never suppressed so zero shows as "0".
  always_comb begin
    lz_off   = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run  = zero_run && (display_q[NIBBLE_W*i +: NIBBLE_W] == '0);
      lz_off[i] = zero_run;
    end
  end
`else
  assign lz_off = '0;
`endif

  always_comb begin
    wrap  = tick && (idx_q == LAST_IDX);
    idx_d = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;

    shadow_d  = load_i ? value_i : shadow_q;
    // A load landing on the frame boundary bypasses the shadow so it is seen immediately.
    display_d = display_q;
    if (wrap) display_d = load_i ? value_i : shadow_q;

    x_d  = display_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
    en_d = enable_i ? ((NUM_DIGITS'(1) << idx_q) & ~blank_i & ~lz_off) : '0;
    fd_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      shadow_q  <= '0;
      display_q <= '0;
      x_q       <= '0;
      en_q      <= '0;
      fd_q      <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
      x_q       <= x_d;
      en_q      <= en_d;
      fd_q      <= fd_d;
    end
  end

  assign x_o          = x_q;
  assign digit_en_o   = en_q;
  assign frame_done_o = fd_q;
endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with 4 digits and a 4-cycle dwell.
module tb_sevenseg_scan;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic        load_i;
  logic [15:0] value_i;
  logic [3:0]  blank_i;
  logic [3:0]  x_o;
  logic [3:0]  digit_en_o;
  logic        frame_done_o;

  int checks   = 0;
  int failures = 0;

  logic [3:0] cap_x  [16];
  logic [3:0] cap_en [16];
  logic       cap_fd [16];

`ifdef SEVENSEG_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  sevenseg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .load_i       (load_i),
    .value_i      (value_i),
    .blank_i      (blank_i),
    .x_o          (x_o),
    .digit_en_o   (digit_en_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  // Expected {x, digit_en, frame_done} for cycle k (0..15) of a frame.
  function automatic logic [8:0] frame_word(input logic [15:0] v, input logic [3:0] off, input int k);
    logic [3:0] nib, oh;
    nib = v[4*(k/4) +: 4];
    oh  = 4'b0001 << (k/4);
    return {nib, oh & ~off, (k == 15)};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Records one 16-cycle frame; optionally strobes load_i so it is sampled on edge load_at+1.
  task automatic capture_frame(input int load_at, input logic [15:0] lv);
    for (int k = 1; k <= 16; k++) begin
      step();
      cap_x[k-1]  = x_o;
      cap_en[k-1] = digit_en_o;
      cap_fd[k-1] = frame_done_o;
      load_i = (k == load_at);
      if (k == load_at) value_i = lv;
    end
    load_i = 1'b0;
  endtask

  task automatic wait_frame(output bit ok);
    int n = 0;
    while (frame_done_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    ok = (frame_done_o === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable_i = 1'b0; load_i = 1'b0; value_i = '0; blank_i = '0;
    repeat (2) step();
    checks++;
    if ({x_o, digit_en_o, frame_done_o} !== 9'h000) begin
      failures++; $display("FAIL reset_idle got=%h exp=000", {x_o, digit_en_o, frame_done_o});
    end
    enable_i = 1'b1; load_i = 1'b1; value_i = 16'hFFFF;
    step();
    checks++;
    if ({x_o, digit_en_o, frame_done_o} !== 9'h000) begin
      failures++; $display("FAIL reset_held got=%h exp=000", {x_o, digit_en_o, frame_done_o});
    end
    enable_i = 1'b0; load_i = 1'b0;
  endtask

  task automatic test_scan();
    bit ok;
    rst = 1'b0; enable_i = 1'b1; load_i = 1'b1; value_i = 16'h1234;
    step();
    load_i = 1'b0; value_i = 16'hFFFF;
    wait_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL scan_first_frame got=timeout exp=frame_done"); end
    capture_frame(-1, 16'h0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({cap_x[k], cap_en[k], cap_fd[k]} !== frame_word(16'h1234, 4'b0000, k)) begin
        failures++; $display("FAIL scan k=%0d got=%h exp=%h", k, {cap_x[k], cap_en[k], cap_fd[k]}, frame_word(16'h1234, 4'b0000, k));
      end
    end
  endtask

  task automatic test_midframe_load();
    capture_frame(6, 16'hABCD);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({cap_x[k], cap_en[k], cap_fd[k]} !== frame_word(16'h1234, 4'b0000, k)) begin
        failures++; $display("FAIL mid_cur k=%0d got=%h exp=%h", k, {cap_x[k], cap_en[k], cap_fd[k]}, frame_word(16'h1234, 4'b0000, k));
      end
    end
    capture_frame(-1, 16'h0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({cap_x[k], cap_en[k], cap_fd[k]} !== frame_word(16'hABCD, 4'b0000, k)) begin
        failures++; $display("FAIL mid_next k=%0d got=%h exp=%h", k, {cap_x[k], cap_en[k], cap_fd[k]}, frame_word(16'hABCD, 4'b0000, k));
      end
    end
  endtask

  task automatic test_load_on_wrap();
    capture_frame(15, 16'h5555);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({cap_x[k], cap_en[k], cap_fd[k]} !== frame_word(16'hABCD, 4'b0000, k)) begin
        failures++; $display("FAIL wrap_cur k=%0d got=%h exp=%h", k, {cap_x[k], cap_en[k], cap_fd[k]}, frame_word(16'hABCD, 4'b0000, k));
      end
    end
    capture_frame(-1, 16'h0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({cap_x[k], cap_en[k], cap_fd[k]} !== frame_word(16'h5555, 4'b0000, k)) begin
        failures++; $display("FAIL wrap_next k=%0d got=%h exp=%h", k, {cap_x[k], cap_en[k], cap_fd[k]}, frame_word(16'h5555, 4'b0000, k));
      end
    end
  endtask

  task automatic test_blank();
    blank_i = 4'b0101;
    capture_frame(3, 16'h9876);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({cap_x[k], cap_en[k], cap_fd[k]} !== frame_word(16'h5555, 4'b0101, k)) begin
        failures++; $display("FAIL blank_shadow k=%0d got=%h exp=%h", k, {cap_x[k], cap_en[k], cap_fd[k]}, frame_word(16'h5555, 4'b0101, k));
      end
    end
    capture_frame(-1, 16'h0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({cap_x[k], cap_en[k], cap_fd[k]} !== frame_word(16'h9876, 4'b0101, k)) begin
        failures++; $display("FAIL blank k=%0d got=%h exp=%h", k, {cap_x[k], cap_en[k], cap_fd[k]}, frame_word(16'h9876, 4'b0101, k));
      end
    end
    blank_i = 4'b0000;
  endtask

  task automatic test_enable();
    repeat (9) step();
    checks++;
    if ({x_o, digit_en_o} !== 8'h84) begin
      failures++; $display("FAIL en_before got=%h exp=84", {x_o, digit_en_o});
    end
    enable_i = 1'b0; load_i = 1'b1; value_i = 16'h4321;
    for (int c = 0; c < 10; c++) begin
      step();
      load_i = 1'b0;
      checks++;
      if ({digit_en_o, frame_done_o} !== 5'b0) begin
        failures++; $display("FAIL en_off c=%0d got=%b exp=00000", c, {digit_en_o, frame_done_o});
      end
    end
    enable_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({x_o, digit_en_o} !== 8'h84) begin
        failures++; $display("FAIL en_resume c=%0d got=%h exp=84", c, {x_o, digit_en_o});
      end
    end
    step();
    checks++;
    if ({x_o, digit_en_o} !== 8'h98) begin
      failures++; $display("FAIL en_advance got=%h exp=98", {x_o, digit_en_o});
    end
    repeat (3) step();
    checks++;
    if (frame_done_o !== 1'b1) begin
      failures++; $display("FAIL en_frame_done got=%b exp=1", frame_done_o);
    end
    capture_frame(-1, 16'h0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({cap_x[k], cap_en[k], cap_fd[k]} !== frame_word(16'h4321, 4'b0000, k)) begin
        failures++; $display("FAIL en_load k=%0d got=%h exp=%h", k, {cap_x[k], cap_en[k], cap_fd[k]}, frame_word(16'h4321, 4'b0000, k));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_en;
    repeat (5) step();
    checks++;
    if ({x_o, digit_en_o} !== 8'h22) begin
      failures++; $display("FAIL arst_pre got=%h exp=22", {x_o, digit_en_o});
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({x_o, digit_en_o, frame_done_o} !== 9'h000) begin
      failures++; $display("FAIL arst_async got=%h exp=000", {x_o, digit_en_o, frame_done_o});
    end
    #1 rst = 1'b0;
    step();
    checks++;
    if ({x_o, digit_en_o} !== 8'h01) begin
      failures++; $display("FAIL arst_restart got=%h exp=01", {x_o, digit_en_o});
    end
    repeat (4) step();
    exp_en = LZ ? 4'b0000 : 4'b0010;
    checks++;
    if ({x_o, digit_en_o} !== {4'h0, exp_en}) begin
      failures++; $display("FAIL arst_digit1 got=%h exp=%h", {x_o, digit_en_o}, {4'h0, exp_en});
    end
  endtask

  task automatic test_lz();
    bit ok;
    logic [3:0] off;
    load_i = 1'b1; value_i = 16'h0040;
    step();
    load_i = 1'b0;
    wait_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL lz_frame got=timeout exp=frame_done"); end
    capture_frame(15, 16'h0000);
    off = LZ ? 4'b1100 : 4'b0000;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({cap_x[k], cap_en[k], cap_fd[k]} !== frame_word(16'h0040, off, k)) begin
        failures++; $display("FAIL lz_0040 k=%0d got=%h exp=%h", k, {cap_x[k], cap_en[k], cap_fd[k]}, frame_word(16'h0040, off, k));
      end
    end
    capture_frame(-1, 16'h0);
    off = LZ ? 4'b1110 : 4'b0000;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({cap_x[k], cap_en[k], cap_fd[k]} !== frame_word(16'h0000, off, k)) begin
        failures++; $display("FAIL lz_zero k=%0d got=%h exp=%h", k, {cap_x[k], cap_en[k], cap_fd[k]}, frame_word(16'h0000, off, k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe_load();
    test_load_on_wrap();
    test_blank();
    test_enable();
    test_async_reset();
    test_lz();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
